// File: rtl/uart_bus_ctrl.sv
// Core-side UART controller: DATA/STATUS/CTRL register window, TX push / RX pop sequencing, parity config.
// Latency: ack one cycle after req is sampled in IDLE, or one cycle after a blocking FIFO condition clears.
// Backpressure: stall = req & ~ack; waits in TX_WAIT/RX_WAIT while tx_full / rx_empty (optional RX timeout: UART_CTRL_RX_TIMEOUT_EN).
module uart_bus_ctrl #(
   parameter logic DEF_PARITY_EN   = 1'b1,
   parameter logic DEF_PARITY_TYPE = 1'b0,
   parameter int   RX_TIMEOUT      = 1024
) (
   input  logic       i_uart_ctrl_clk,
   input  logic       i_uart_ctrl_rst,
   input  logic       i_uart_ctrl_req,
   input  logic       i_uart_ctrl_we,
   input  logic [1:0] i_uart_ctrl_addr,
   input  logic [7:0] i_uart_ctrl_wdata,
   output logic [7:0] o_uart_ctrl_rdata,
   output logic       o_uart_ctrl_ack,
   output logic       o_uart_ctrl_stall,
   input  logic       i_uart_ctrl_tx_full,
   input  logic       i_uart_ctrl_rx_empty,
   input  logic [7:0] i_uart_ctrl_rx_pdata,
   output logic       o_uart_ctrl_tx_valid,
   output logic [7:0] o_uart_ctrl_tx_pdata,
   output logic       o_uart_ctrl_rx_request,
   output logic       o_uart_ctrl_parity_en,
   output logic       o_uart_ctrl_parity_type
);

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   typedef enum logic [1:0] {IDLE, TX_WAIT, RX_WAIT, RESP} state_t;

   state_t     state, state_nxt;
   logic [1:0] ctrl;
   logic [7:0] rdata_nxt;
   logic       push, pop, ctrl_wr, load_wdata;
   logic       timeout_flag;
   logic [7:0] status;

`ifdef UART_CTRL_RX_TIMEOUT_EN
   localparam int CW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
   logic [CW-1:0] to_cnt;
   logic          to_fire, status_rd;
`else
   // Without the timeout option there is no counter and the flag reads as zero.
   assign timeout_flag = 1'b0;
`endif

   assign status                  = {3'b000, ctrl[1], ctrl[0], timeout_flag, i_uart_ctrl_rx_empty, i_uart_ctrl_tx_full};
   assign o_uart_ctrl_stall       = i_uart_ctrl_req & ~o_uart_ctrl_ack;
   assign o_uart_ctrl_parity_en   = ctrl[0];
   assign o_uart_ctrl_parity_type = ctrl[1];

   // State register.
   always_ff @(posedge i_uart_ctrl_clk or posedge i_uart_ctrl_rst) begin
      if (i_uart_ctrl_rst) state <= IDLE;
      else                 state <= state_nxt;
   end

   // Next-state decode; request fields only matter in IDLE, the WAIT states replay that decision.
   always_comb begin
      state_nxt  = state;
      rdata_nxt  = 8'h00;
      push       = 1'b0;
      pop        = 1'b0;
      ctrl_wr    = 1'b0;
      load_wdata = 1'b0;
`ifdef UART_CTRL_RX_TIMEOUT_EN
      to_fire    = 1'b0;
      status_rd  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (i_uart_ctrl_req) begin
               state_nxt = RESP;
               case (i_uart_ctrl_addr)
                  ADDR_DATA: begin
                     if (i_uart_ctrl_we) begin
                        load_wdata = 1'b1;
                        if (i_uart_ctrl_tx_full) state_nxt = TX_WAIT;
                        else                     push      = 1'b1;
                     end else begin
                        if (i_uart_ctrl_rx_empty) state_nxt = RX_WAIT;
                        else begin
                           pop       = 1'b1;
                           rdata_nxt = i_uart_ctrl_rx_pdata;
                        end
                     end
                  end
                  ADDR_STATUS: begin
                     if (!i_uart_ctrl_we) begin
                        rdata_nxt = status;
`ifdef UART_CTRL_RX_TIMEOUT_EN
                        status_rd = 1'b1;
`endif
                     end
                  end
                  ADDR_CTRL: begin
                     if (i_uart_ctrl_we) ctrl_wr   = 1'b1;
                     else                rdata_nxt = {6'b0, ctrl};
                  end
                  default: rdata_nxt = 8'h00;
               endcase
            end
         end
         TX_WAIT: begin
            if (!i_uart_ctrl_tx_full) begin
               push      = 1'b1;
               state_nxt = RESP;
            end
         end
         RX_WAIT: begin
            if (!i_uart_ctrl_rx_empty) begin
               pop       = 1'b1;
               rdata_nxt = i_uart_ctrl_rx_pdata;
               state_nxt = RESP;
            end
`ifdef UART_CTRL_RX_TIMEOUT_EN
            else if (to_cnt == CW'(RX_TIMEOUT - 1)) begin
               to_fire   = 1'b1;
               rdata_nxt = 8'hFF;
               state_nxt = RESP;
            end
`endif
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs: push/pop pulses and read data land in the RESP cycle alongside ack.
   always_ff @(posedge i_uart_ctrl_clk or posedge i_uart_ctrl_rst) begin
      if (i_uart_ctrl_rst) begin
         o_uart_ctrl_rdata      <= 8'h00;
         o_uart_ctrl_ack        <= 1'b0;
         o_uart_ctrl_tx_valid   <= 1'b0;
         o_uart_ctrl_tx_pdata   <= 8'h00;
         o_uart_ctrl_rx_request <= 1'b0;
         ctrl                   <= {DEF_PARITY_TYPE, DEF_PARITY_EN};
      end else begin
         o_uart_ctrl_rdata      <= rdata_nxt;
         o_uart_ctrl_ack        <= (state != RESP) && (state_nxt == RESP);
         o_uart_ctrl_tx_valid   <= push;
         o_uart_ctrl_rx_request <= pop;
         if (load_wdata) o_uart_ctrl_tx_pdata <= i_uart_ctrl_wdata;
         if (ctrl_wr)    ctrl                 <= i_uart_ctrl_wdata[1:0];
      end
   end

`ifdef UART_CTRL_RX_TIMEOUT_EN
   // Wait counter is held at zero outside RX_WAIT so each wait starts fresh.
   always_ff @(posedge i_uart_ctrl_clk or posedge i_uart_ctrl_rst) begin
      if (i_uart_ctrl_rst)      to_cnt <= '0;
      else if (state != RX_WAIT) to_cnt <= '0;
      else                      to_cnt <= to_cnt + CW'(1);
   end

   // Sticky timeout flag; a STATUS read reports it and clears it on the same edge.
   always_ff @(posedge i_uart_ctrl_clk or posedge i_uart_ctrl_rst) begin
      if (i_uart_ctrl_rst) timeout_flag <= 1'b0;
      else if (to_fire)    timeout_flag <= 1'b1;
      else if (status_rd)  timeout_flag <= 1'b0;
   end
`endif

endmodule
